if_prefetch_queue: RTL and testbench

- Small instruction prefetch FIFO between the instruction fetch stage and the instruction decode stage.
- Buffers {pc, Instruction} pairs produced by fetch, so a decode-side stall does not stall fetch until the queue is full.
- Queue-full backpressure is what fetch sees as its freeze.
- A taken branch flushes all buffered (wrong-path) entries in one cycle.

---
 rtl/if_prefetch_queue.sv | 89 ++++++++
 tb/tb_if_prefetch_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Buffers {pc, instruction} pairs in a circular buffer; a full queue backpressures
// fetch through in_ready, and a taken branch (flush) drops every buffered entry.
module if_prefetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_pc,
  input  logic [DATA_W-1:0]            in_instruction,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_pc,
  output logic [DATA_W-1:0]            out_instruction,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [DATA_W-1:0] pc_mem_q    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push, pop, mem_we;

  // Handshakes and output view; outputs depend only on registered state.
  always_comb begin
    in_ready        = (count_q != CntFull);
    out_valid       = (count_q != '0);
    push            = in_valid & in_ready;
    pop             = out_valid & out_ready;
    // A flushed or reset cycle must not leave a stale write behind.
    mem_we          = push & ~flush & ~rst;
    out_pc          = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    out_instruction = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    count           = count_q;
  end

  // Pointer and occupancy next state; flush overrides any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instruction;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: vector table with explicit expected
// values plus a scoreboard of accepted entries compared as decode consumes them.
module tb_if_prefetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, in_valid, out_ready, flush;
  logic [DATA_W-1:0] in_pc, in_instruction;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_pc, out_instruction;
  logic [2:0]        count;

  if_prefetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .out_ready       (out_ready),
    .flush           (flush),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    int          exp_count;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_out_pc;
  } vec_t;

  entry_t sb[$];
  int     errors = 0;
  int     checks = 0;
  bit     ptr_chk_en = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy must always match the pointer distance (full when pointers meet with count=DEPTH).
  always @(negedge clk) begin
    if (ptr_chk_en) begin
      logic [1:0] diff;
      diff = dut.wr_ptr_q - dut.rd_ptr_q;
      checks++;
      if (count > 3'(DEPTH) || (32'(count) % DEPTH) != 32'(diff)) begin
        errors++;
        $display("FAIL ptr_count: count=%0d wr=%0d rd=%0d", count, dut.wr_ptr_q, dut.rd_ptr_q);
      end
    end
  end

  // One clock: drive at negedge, score pops before the edge, check state after it.
  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic ordy);
    bit     push, pop;
    entry_t e;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instruction = instr_of(pc);
    out_ready = ordy;
    #1;
    push = iv && (sb.size() < DEPTH);
    pop  = ordy && (sb.size() > 0);
    if (pop) begin
      e = sb[0];
      chk("pop_valid", 32'(out_valid), 32'd1);
      chk("pop_pc", out_pc, e.pc);
      chk("pop_instr", out_instruction, e.instr);
    end
    @(posedge clk);
    if (r || f) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        e.pc = pc; e.instr = instr_of(pc);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    ptr_chk_en = 1;
    chk("sb_count", 32'(count), 32'(sb.size()));
    chk("sb_out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("sb_in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    if (sb.size() == 0) begin
      chk("empty_pc", out_pc, 32'd0);
      chk("empty_instr", out_instruction, 32'd0);
    end else begin
      chk("head_pc", out_pc, sb[0].pc);
      chk("head_instr", out_instruction, sb[0].instr);
    end
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instruction = '0;
    out_ready = 1'b0;

    //                rst flush iv  pc      ordy cnt ir  ov  out_pc
    // Reset then fill
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'd0,   1'b0, 0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'd99,  1'b1, 0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd4,   1'b0, 1, 1'b1, 1'b1, 32'd4});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd8,   1'b0, 2, 1'b1, 1'b1, 32'd4});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd12,  1'b0, 3, 1'b1, 1'b1, 32'd4});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd16,  1'b0, 4, 1'b0, 1'b1, 32'd4});
    // Full: fetch holds pc=20; then simultaneous pop, push refused
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd20,  1'b0, 4, 1'b0, 1'b1, 32'd4});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd20,  1'b1, 3, 1'b1, 1'b1, 32'd8});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd20,  1'b1, 3, 1'b1, 1'b1, 32'd12});
    // Drain across the pointer wrap
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 2, 1'b1, 1'b1, 32'd16});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 1, 1'b1, 1'b1, 32'd20});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd24,  1'b0, 1, 1'b1, 1'b1, 32'd24});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd28,  1'b0, 2, 1'b1, 1'b1, 32'd24});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 1, 1'b1, 1'b1, 32'd28});
    // Flush mid-stream at count=3 with push and pop pending
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd32,  1'b0, 2, 1'b1, 1'b1, 32'd28});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd36,  1'b0, 3, 1'b1, 1'b1, 32'd28});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd40,  1'b1, 0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1, 1'b1, 1'b1, 32'h100});
    // Reset mid-operation at count=2 with a push pending
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 2, 1'b1, 1'b1, 32'h100});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 0, 1'b1, 1'b0, 32'd0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
      chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].exp_out_pc);
    end

    // Steady streaming: occupancy stays at 1, output lags input by one cycle
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'(4 * k), 1'b1);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc", out_pc, 32'(4 * k));
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_drain_valid", 32'(out_valid), 32'd0);

    // Flush on a full queue, then refill immediately
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 32'h200 + 32'(4 * k), 1'b0);
    chk("refill_full", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
    chk("flush_full_count", 32'(count), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h304, 1'b1);
    chk("after_flush_pc", out_pc, 32'h304);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
